lut_mul_seq: RTL and testbench
==============================

// Module: lut_mul_seq
// PURPOSE
//   Sequential W x W multiplier built on an N x N product lookup table, the
//   multi-cycle successor of the single-lookup product ROM.
//   Operands are split into DIGITS digits of N bits. One digit-pair partial
//   product is looked up per cycle and accumulated at its shifted position.
//   Valid/ready handshakes on input and output; sits between operand source and
//   result consumer in the arithmetic datapath.
// PARAMETERS
//   N       2   digit width in bits; LUT has 2**(2N) entries of 2N bits
//   DIGITS  4   digits per operand; operand width W = N*DIGITS
// PORTS
//   clk        in   1    single clock, all state on rising edge
//   rst        in   1    synchronous, active-high reset
//   in_valid   in   1    operands a/b valid
//   in_ready   out  1    block can accept operands (combinational from state)
//   a          in   W    multiplicand
//   b          in   W    multiplier
//   out_valid  out  1    product valid, held until taken
//   out_ready  in   1    consumer takes product
//   product    out  2W   result
//   busy       out  1    high in RUN or DONE
// BEHAVIOUR
//   Reset (rst=1 at edge): state=IDLE, acc=0, i=j=0, out_valid=0, product=0.
//     in_ready is 0 while rst is high, otherwise (state==IDLE).
//     rst at any cycle aborts a run; no partial result is ever presented.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid: latch a,b; acc=0; i=j=0; go to RUN.
//   RUN: each cycle acc += lut[{a_dig[i],b_dig[j]}] << (N*(i+j)).
//     j counts 0..DIGITS-1; when j wraps to 0, i increments.
//     On the edge with i==j==DIGITS-1: product <= final sum; out_valid <= 1; go to DONE.
//   Latency: out_valid rises exactly DIGITS**2 cycles after the accepting edge.
//   DONE: out_valid=1; product stable. On out_ready: out_valid <= 0; go to IDLE.
//     Next operands can be accepted on the following cycle (no bypass).
//   in_valid outside IDLE is ignored; a/b changes outside IDLE have no effect.
//   acc is 2W bits wide; the sum cannot overflow (max (2**W-1)**2 < 2**2W).
//   LUT contents = i*j computed at elaboration (no external file); lookup is
//   combinational.
// CONFIGURATION
//   `LUT_MUL_SIGNED_EN defined: a, b, product are two's complement.
//     At accept, magnitudes |a| and |b| are latched (W bits unsigned; -2**(W-1) is exact)
//     and sign = a[W-1]^b[W-1] is latched.
//     At the final RUN edge, product <= sign ? -acc : acc (2W-bit wrap).
//   Undefined: a, b, product are unsigned; no sign logic is synthesised.
// STRUCTURE
//   Package lut_mul_pkg: state typedef (IDLE/RUN/DONE), function digit_idx_w(DIGITS)
//     returning the counter width.
//   Sub-module lut_mul_table #(N): address 2N in, data 2N out, combinational
//     product table; the only instance in lut_mul_seq.
// TESTING (N=2, DIGITS=4, W=8)
//   a=8'hFF, b=8'hFF -> product=16'hFE01; out_valid exactly 16 cycles after accept.
//   a=8'h00, b=8'hA5 -> product=0; a=8'h01, b=8'h80 -> 16'h0080.
//   Back-pressure: out_ready=0 for 5 cycles after out_valid -> product stable,
//     in_ready=0, new in_valid ignored. out_ready=1 -> IDLE and next op accepted.
//   rst pulsed at RUN cycle 7 -> out_valid never rises; in_ready=1 the cycle after;
//     next op 8'h0C*8'h0D gives 16'h009C.
//   Back-to-back: 20 random pairs with out_ready held 1 -> all products match reference model.
//   SIGNED_EN: -128*-128 -> 16'h4000; -1*1 -> 16'hFFFF; -7*6 -> 16'hFFD6.

Source files
------------

// File: rtl/lut_mul_pkg.sv
// rtl/lut_mul_pkg.sv - shared state type and sizing helper for the LUT-based sequential multiplier
package lut_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width of a digit counter that must reach digits-1; never narrower than one bit.
    function automatic int digit_idx_w(input int digits);
        int w;
        w = $clog2(digits);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lut_mul_table.sv
// rtl/lut_mul_table.sv - combinational N x N digit product table, contents fixed at elaboration
module lut_mul_table #(
    parameter int N = 2
) (
    input  logic [2*N-1:0] i_addr,
    output logic [2*N-1:0] o_data
);

    localparam int AW      = 2 * N;
    localparam int ENTRIES = 2 ** AW;

    logic [AW-1:0] w_rom [ENTRIES];

    // Entry k holds (upper digit of k) * (lower digit of k); the product of two N-bit values fits in 2N bits.
    for (genvar k = 0; k < ENTRIES; k++) begin : g_rom
        assign w_rom[k] = AW'((k / (2 ** N)) * (k % (2 ** N)));
    end

    assign o_data = w_rom[i_addr];

endmodule

// File: rtl/lut_mul_seq.sv
// rtl/lut_mul_seq.sv - sequential W x W multiplier, one digit-pair lookup per cycle; optional signed mode via LUT_MUL_SIGNED_EN
module lut_mul_seq
    import lut_mul_pkg::*;
#(
    parameter  int N      = 2,
    parameter  int DIGITS = 4,
    localparam int W      = N * DIGITS
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*W-1:0] product,
    output logic           busy
);

    localparam int            CW       = digit_idx_w(DIGITS);
    localparam int            PW       = 2 * W;
    localparam logic [CW-1:0] LAST_IDX = CW'(DIGITS - 1);

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_a;
    logic [W-1:0]   r_b;
    logic [CW-1:0]  r_i;
    logic [CW-1:0]  r_j;
    logic [PW-1:0]  r_acc;
    logic [PW-1:0]  r_product;
    logic           r_out_valid;

    logic [N-1:0]   w_a_digs [DIGITS];
    logic [N-1:0]   w_b_digs [DIGITS];
    logic [N-1:0]   w_a_dig;
    logic [N-1:0]   w_b_dig;
    logic [2*N-1:0] w_lut_data;
    logic [PW-1:0]  w_pp;
    logic [PW-1:0]  w_sum;
    logic [PW-1:0]  w_result;
    logic [W-1:0]   w_a_load;
    logic [W-1:0]   w_b_load;
    logic           w_last;

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        assign w_a_digs[d] = r_a[d*N +: N];
        assign w_b_digs[d] = r_b[d*N +: N];
    end

    assign w_a_dig = w_a_digs[r_i];
    assign w_b_dig = w_b_digs[r_j];

    lut_mul_table #(
        .N (N)
    ) u_table (
        .i_addr (({w_a_dig, w_b_dig})),
        .o_data (w_lut_data)
    );

    assign w_pp   = PW'(w_lut_data) << (N * (int'(r_i) + int'(r_j)));
    assign w_sum  = r_acc + w_pp;
    assign w_last = (r_i == LAST_IDX) && (r_j == LAST_IDX);

`ifdef LUT_MUL_SIGNED_EN
    logic r_sign;

    // Magnitudes are W-bit unsigned, so the most negative operand maps to 2**(W-1) exactly.
    assign w_a_load = a[W-1] ? (~a + W'(1)) : a;
    assign w_b_load = b[W-1] ? (~b + W'(1)) : b;
    assign w_result = r_sign ? (~w_sum + PW'(1)) : w_sum;

    // Operand sign captured once at accept; the accumulator only ever sees magnitudes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sign <= 1'b0;
        end else if (r_state == ST_IDLE && in_valid) begin
            r_sign <= a[W-1] ^ b[W-1];
        end
    end
`else
    assign w_a_load = a;
    assign w_b_load = b;
    assign w_result = w_sum;
`endif

    assign in_ready  = !rst && (r_state == ST_IDLE);
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);

    // State register; reset from any state abandons the run in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: accept in IDLE, finish on the last digit pair, release when the consumer takes the result.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)  w_state_nxt = ST_RUN;
            ST_RUN:  if (w_last)    w_state_nxt = ST_DONE;
            ST_DONE: if (out_ready) w_state_nxt = ST_IDLE;
            default:                w_state_nxt = ST_IDLE;
        endcase
    end

    // Datapath: latch operands, walk j fastest then i, accumulate shifted partial products.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a         <= '0;
            r_b         <= '0;
            r_i         <= '0;
            r_j         <= '0;
            r_acc       <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a   <= w_a_load;
                        r_b   <= w_b_load;
                        r_acc <= '0;
                        r_i   <= '0;
                        r_j   <= '0;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_sum;
                    if (w_last) begin
                        r_i         <= '0;
                        r_j         <= '0;
                        r_product   <= w_result;
                        r_out_valid <= 1'b1;
                    end else if (r_j == LAST_IDX) begin
                        r_j <= '0;
                        r_i <= r_i + CW'(1);
                    end else begin
                        r_j <= r_j + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lut_mul_seq.sv
// tb/tb_lut_mul_seq.sv - directed table and sequence bench for lut_mul_seq (N=2, DIGITS=4)
module tb_lut_mul_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    lut_mul_seq #(
        .N      (2),
        .DIGITS (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y);
`ifdef LUT_MUL_SIGNED_EN
        return 16'(int'($signed(x)) * int'($signed(y)));
`else
        return 16'(int'(x) * int'(y));
`endif
    endfunction

    // One full transaction: accept, count latency, optionally hold back-pressure, then release.
    task automatic do_op(input logic [7:0] oa, input logic [7:0] ob, input logic [15:0] exp,
                         input int hold, input logic keep_ready, input string nm);
        int          n;
        logic [15:0] held;
        @(negedge clk);
        chk({nm, "_in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a        = oa;
        b        = ob;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'($urandom);
        b        = 8'($urandom);
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({nm, "_latency"}, 32'(n), 32'd16);
        chk({nm, "_product"}, 32'(product), 32'(exp));
        held = product;
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'b1;
            a        = 8'($urandom);
            b        = 8'($urandom);
            @(posedge clk);
            #1;
            chk({nm, "_hold_valid"}, 32'(out_valid), 32'd1);
            chk({nm, "_hold_product"}, 32'(product), 32'(held));
            chk({nm, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = keep_ready;
        chk({nm, "_released"}, 32'(out_valid), 32'd0);
        chk({nm, "_idle_ready"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic       seen;
        logic [7:0] ra;
        logic [7:0] rb;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 8'h00;
        b         = 8'h00;

`ifdef LUT_MUL_SIGNED_EN
        vecs.push_back('{8'h80, 8'h80, 16'h4000});
        vecs.push_back('{8'hFF, 8'h01, 16'hFFFF});
        vecs.push_back('{8'hF9, 8'h06, 16'hFFD6});
        vecs.push_back('{8'h7F, 8'h81, 16'hC0FF});
        vecs.push_back('{8'h00, 8'hFF, 16'h0000});
        vecs.push_back('{8'h0C, 8'h0D, 16'h009C});
`else
        vecs.push_back('{8'hFF, 8'hFF, 16'hFE01});
        vecs.push_back('{8'h00, 8'hA5, 16'h0000});
        vecs.push_back('{8'h01, 8'h80, 16'h0080});
        vecs.push_back('{8'h0C, 8'h0D, 16'h009C});
        vecs.push_back('{8'hAA, 8'h55, 16'h3872});
        vecs.push_back('{8'h10, 8'h10, 16'h0100});
        vecs.push_back('{8'h80, 8'h02, 16'h0100});
`endif

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Table vectors
        for (int v = 0; v < vecs.size(); v++) begin
            do_op(vecs[v].a, vecs[v].b, vecs[v].p, 0, 1'b0, $sformatf("vec%0d", v));
        end

        // Back-pressure: hold for 5 cycles with competing in_valid, then the next op must still work
        do_op(8'h5A, 8'h03, 16'h010E, 5, 1'b0, "bp");
        do_op(8'h0C, 8'h0D, 16'h009C, 0, 1'b0, "after_bp");

        // Reset during RUN cycle 7
        @(negedge clk);
        in_valid = 1'b1;
        a        = 8'h7F;
        b        = 8'h7F;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        chk("abort_busy_before", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("abort_in_ready_rst", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_in_ready_after", 32'(in_ready), 32'd1);
        chk("abort_product", 32'(product), 32'd0);
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 32'(seen), 32'd0);
        do_op(8'h0C, 8'h0D, 16'h009C, 0, 1'b0, "after_abort");

        // Back-to-back random pairs with out_ready held high
        out_ready = 1'b1;
        for (int r = 0; r < 20; r++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            do_op(ra, rb, ref_mul(ra, rb), 0, 1'b1, $sformatf("b2b%0d", r));
        end
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
